// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map and STATUS layout shared by the data-bus
// responder and its TX FIFO.
//   RAM_SEL_BIT        address bit that selects MMIO (1) or RAM (0)
//   *_OFF              MMIO word offsets, decoded from addr[3:2]
//   ST_*               STATUS register bit positions
//   status_word()      packs the FIFO/overflow flags into a STATUS read value
package mem_map_pkg;

  localparam int RAM_SEL_BIT = 31;

  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] CYCLE_OFF  = 2'd2;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_COUNT_LSB = 4;

  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] cnt);
    logic [31:0] w;
    w = '0;
    w[ST_FULL_BIT]                  = full;
    w[ST_EMPTY_BIT]                 = empty;
    w[ST_OVF_BIT]                   = ovf;
    w[ST_COUNT_LSB +: 4]            = cnt;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte-wide first-word-fall-through FIFO feeding the TX drain port.
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write request and byte; ignored when full unless a
//                       pop happens on the same edge
//   pop                 remove head byte (ignored when empty)
//   full, empty, count  occupancy, all decoded from registers only
//   head                current head byte, 0x00 while empty
module tx_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly PW bits, so wrap modulo FIFO_DEPTH is free.
  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays get no reset; occupancy is tracked by the pointers
  // and count, and resetting the array would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Gating keeps the output at 0x00 after reset while storage is stale.
  assign head = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory responder for the core (single-cycle or
// pipelined). Word RAM below 0x8000_0000, MMIO above it.
//   clk, reset          clock, asynchronous active-high reset
//   MemWrite            store strobe
//   ALUResult           byte address (addr[1:0] ignored, word access only)
//   WriteData           store data
//   ReadData            load data, combinational from ALUResult
//   tx_valid, tx_data   TX FIFO head (registered), tx_ready pops it
// MMIO: 0x0 TXDATA (push byte), 0x4 STATUS (write clears overflow),
//       0x8 CYCLE (free-running, writable), 0xC reserved.
module data_bus_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle;
  logic          overflow;

  logic          is_mmio;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          tx_push;
  logic          status_wr;
  logic          cycle_wr;
  logic          tx_pop;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_addr_bits;

  // Upper RAM address bits alias, and byte offset bits are don't-care.
  assign unused_addr_bits = ^{ALUResult[30:AW+2], ALUResult[1:0]};

  assign is_mmio   = ALUResult[RAM_SEL_BIT];
  assign mmio_off  = ALUResult[3:2];
  assign ram_idx   = ALUResult[AW+1:2];

  assign ram_we    = MemWrite && !is_mmio;
  assign tx_push   = MemWrite && is_mmio && (mmio_off == TXDATA_OFF);
  assign status_wr = MemWrite && is_mmio && (mmio_off == STATUS_OFF);
  assign cycle_wr  = MemWrite && is_mmio && (mmio_off == CYCLE_OFF);
  assign tx_pop    = tx_valid && tx_ready;

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (WriteData[7:0]),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data)
  );

  assign tx_valid = !fifo_empty;

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= WriteData;
  end

  // A write takes priority over the increment; counting resumes from the
  // loaded value on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cycle <= '0;
    else if (cycle_wr) cycle <= WriteData;
    else               cycle <= cycle + 32'd1;
  end

  // Only a push that the FIFO actually drops raises the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    overflow <= 1'b0;
    else if (status_wr)                           overflow <= 1'b0;
    else if (tx_push && fifo_full && !tx_pop)     overflow <= 1'b1;
  end

  // NOTE: ReadData gets a default before the branches so no path through
  // this block leaves it unassigned and infers a latch.
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[ram_idx];
    end else begin
      case (mmio_off)
        STATUS_OFF: ReadData = status_word(fifo_full, fifo_empty, overflow,
                                           4'(fifo_count));
        CYCLE_OFF:  ReadData = cycle;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule
